scaler_frame_ctl: RTL and testbench
===================================

Name: scaler_frame_ctl

Overview:
- Frame-level sequencer for a horizontal/vertical pair of scaler cores.
- Holds the shadow and active scaling configuration, and applies a new configuration only at frame boundaries.
- Drives the cores' s_nbr/m_nbr, synchronous re-init and enable, counts completed output lines, and reports frame completion.
- Sits between the register/control interface and the two scaler instances in the video scaling path.

Parameters:
- C_S_WIDTH, 12, bit width of source dimensions (src_w, src_h)
- C_M_WIDTH, 12, bit width of destination dimensions (dst_w, dst_h)
- C_INIT_CYC, 2, cycles sc_resetn is held low at each frame start (must be >=1)

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- cfg_src_w  in  C_S_WIDTH  requested source width
- cfg_src_h  in  C_S_WIDTH  requested source height
- cfg_dst_w  in  C_M_WIDTH  requested destination width
- cfg_dst_h  in  C_M_WIDTH  requested destination height
- cfg_update  in  1  one-cycle pulse: capture cfg_* into shadow
- start  in  1  one-cycle frame-start request
- abort  in  1  level; forces return to IDLE
- pause  in  1  level; gates sc_enable while RUN
- line_done  in  1  one-cycle pulse per completed output line (from datapath)
- h_s_nbr  out  C_S_WIDTH  active src_w to horizontal core
- h_m_nbr  out  C_M_WIDTH  active dst_w to horizontal core
- v_s_nbr  out  C_S_WIDTH  active src_h to vertical core
- v_m_nbr  out  C_M_WIDTH  active dst_h to vertical core
- sc_resetn  out  1  synchronous active-low re-init to both cores
- sc_enable  out  1  enable to both cores
- busy  out  1  high from LOAD through DONE
- done  out  1  one-cycle frame-complete pulse
- cfg_err  out  1  sticky: a start was rejected for an invalid config
- start_ovr  out  1  one-cycle pulse: start ignored while busy
- line_cnt  out  C_M_WIDTH  output lines completed in the current frame

Behaviour:
- Reset (resetn=0): state=IDLE; shadow and active registers=0; shadow_vld=0; all *_nbr=0; sc_resetn=0; sc_enable=0; busy=0; done=0; cfg_err=0; start_ovr=0; line_cnt=0.
- Shadow capture:
  - cfg_update in any state writes all four cfg_* into shadow and sets shadow_vld=1.
  - The active registers are unaffected until LOAD.
- States are IDLE, LOAD, INIT, RUN, DONE.
- IDLE:
  - sc_resetn=0, sc_enable=0, busy=0.
  - On start: if the effective config (cfg_* when cfg_update is asserted in the same cycle, else shadow) has any dimension ==0 or shadow_vld==0 with no same-cycle update, then set cfg_err=1 and stay in IDLE.
  - Otherwise go to LOAD.
- LOAD (1 cycle): active <= effective config; line_cnt <= 0; busy=1; next state INIT.
  - *_nbr reflect the active config from the cycle after LOAD.
- INIT:
  - sc_resetn=0 for exactly C_INIT_CYC cycles, counted from INIT entry, with *_nbr already stable.
  - Then RUN.
- RUN:
  - sc_resetn=1; sc_enable = ~pause, registered, so it lags pause by 1 cycle.
  - Each line_done increments line_cnt.
  - A line_done while line_cnt==active dst_h-1 goes to DONE instead; line_cnt saturates at dst_h.
- DONE (1 cycle):
  - done=1, sc_enable=0, sc_resetn=0.
  - Next state IDLE; busy drops on IDLE entry.
- line_done outside RUN is ignored.
- start outside IDLE:
  - The start is ignored and start_ovr pulses 1 cycle later.
  - If start coincides with the DONE cycle, it is also ignored with a start_ovr pulse (no back-to-back chaining).
- abort:
  - Has priority over all other inputs. In any non-IDLE state, the next state is IDLE, sc_enable=0, sc_resetn=0.
  - No done pulse; line_cnt is held for debug; the active config is retained.
- cfg_err clears only on a successful start, i.e. on LOAD entry.
- cfg_update during LOAD/INIT/RUN affects only the next frame.
- Reset mid-frame: everything returns to reset values on the next edge; no done pulse.
- All outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
- Basic frame: cfg_update with 1920/1080 -> 1280/720, then start. Expect:
  - busy=1 next cycle; *_nbr=1920,1280,1080,720 after LOAD.
  - sc_resetn low 2 cycles, then high.
  - After 720 line_done pulses, done pulses once, busy=0, line_cnt=720.
- Invalid config:
  - cfg_dst_h=0 plus update, then start -> state stays IDLE, cfg_err=1, busy=0.
  - A valid update followed by start -> cfg_err=0 at LOAD.
- Frame-boundary update: cfg_update with a new dst_w=640 during RUN -> h_m_nbr stays 1280 until the frame ends; the next start shows 640.
- Pause/abort:
  - pause mid-RUN -> sc_enable=0 one cycle later and line_cnt frozen.
  - abort -> IDLE next cycle, no done pulse, sc_resetn=0.
- Overrun and same-cycle events:
  - start during RUN -> start_ovr pulses once, frame unaffected.
  - start+cfg_update in the same IDLE cycle with dst_h=2 -> uses the new config; done after 2 line_done pulses.
- Reset mid-RUN: resetn=0 for 1 cycle at line 100 -> all outputs at reset values, shadow_vld=0, and a subsequent start without update sets cfg_err=1.

Source files
------------

// File: rtl/scaler_frame_ctl.sv
// Frame-level sequencer for the horizontal/vertical scaler pair: double-buffered
// configuration, per-frame core re-init/enable, output line counting.
module scaler_frame_ctl #(
   parameter int C_S_WIDTH  = 12,
   parameter int C_M_WIDTH  = 12,
   parameter int C_INIT_CYC = 2
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [C_S_WIDTH-1:0] cfg_src_w,
   input  logic [C_S_WIDTH-1:0] cfg_src_h,
   input  logic [C_M_WIDTH-1:0] cfg_dst_w,
   input  logic [C_M_WIDTH-1:0] cfg_dst_h,
   input  logic                 cfg_update,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 pause,
   input  logic                 line_done,
   output logic [C_S_WIDTH-1:0] h_s_nbr,
   output logic [C_M_WIDTH-1:0] h_m_nbr,
   output logic [C_S_WIDTH-1:0] v_s_nbr,
   output logic [C_M_WIDTH-1:0] v_m_nbr,
   output logic                 sc_resetn,
   output logic                 sc_enable,
   output logic                 busy,
   output logic                 done,
   output logic                 cfg_err,
   output logic                 start_ovr,
   output logic [C_M_WIDTH-1:0] line_cnt
);

   localparam int C_IW = (C_INIT_CYC > 1) ? $clog2(C_INIT_CYC) : 1;
   localparam logic [C_IW-1:0] C_INIT_LAST = C_IW'(C_INIT_CYC - 1);

   typedef enum logic [2:0] {IDLE, LOAD, INIT, RUN, DONE} state_t;

   state_t                 state;
   state_t                 next_state;
   logic [C_IW-1:0]        init_cnt;
   logic [C_S_WIDTH-1:0]   sh_src_w;
   logic [C_S_WIDTH-1:0]   sh_src_h;
   logic [C_M_WIDTH-1:0]   sh_dst_w;
   logic [C_M_WIDTH-1:0]   sh_dst_h;
   logic                   shadow_vld;
   logic [C_S_WIDTH-1:0]   eff_src_w;
   logic [C_S_WIDTH-1:0]   eff_src_h;
   logic [C_M_WIDTH-1:0]   eff_dst_w;
   logic [C_M_WIDTH-1:0]   eff_dst_h;
   logic                   eff_ok;
   logic                   nxt_sc_resetn;
   logic                   nxt_sc_enable;
   logic                   nxt_busy;
   logic                   nxt_done;
   logic                   nxt_cfg_err;
   logic                   nxt_start_ovr;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sh_src_w   <= '0;
         sh_src_h   <= '0;
         sh_dst_w   <= '0;
         sh_dst_h   <= '0;
         shadow_vld <= 1'b0;
      end else if (cfg_update) begin
         sh_src_w   <= cfg_src_w;
         sh_src_h   <= cfg_src_h;
         sh_dst_w   <= cfg_dst_w;
         sh_dst_h   <= cfg_dst_h;
         shadow_vld <= 1'b1;
      end
   end

   // A same-cycle update takes precedence over the shadow when judging a start.
   always_comb begin
      eff_src_w = cfg_update ? cfg_src_w : sh_src_w;
      eff_src_h = cfg_update ? cfg_src_h : sh_src_h;
      eff_dst_w = cfg_update ? cfg_dst_w : sh_dst_w;
      eff_dst_h = cfg_update ? cfg_dst_h : sh_dst_h;
      eff_ok    = (cfg_update || shadow_vld) &&
                  (eff_src_w != '0) && (eff_src_h != '0) &&
                  (eff_dst_w != '0) && (eff_dst_h != '0);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         init_cnt  <= '0;
         h_s_nbr   <= '0;
         h_m_nbr   <= '0;
         v_s_nbr   <= '0;
         v_m_nbr   <= '0;
         line_cnt  <= '0;
         sc_resetn <= 1'b0;
         sc_enable <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
         start_ovr <= 1'b0;
      end else begin
         state     <= next_state;
         sc_resetn <= nxt_sc_resetn;
         sc_enable <= nxt_sc_enable;
         busy      <= nxt_busy;
         done      <= nxt_done;
         cfg_err   <= nxt_cfg_err;
         start_ovr <= nxt_start_ovr;
         init_cnt  <= (state == INIT) ? init_cnt + 1'b1 : '0;
         // Shadow already holds the effective config by the LOAD cycle.
         if (state == LOAD && !abort) begin
            h_s_nbr  <= sh_src_w;
            h_m_nbr  <= sh_dst_w;
            v_s_nbr  <= sh_src_h;
            v_m_nbr  <= sh_dst_h;
            line_cnt <= '0;
         end else if (state == RUN && line_done && !abort && line_cnt != v_m_nbr) begin
            line_cnt <= line_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      next_state = state;
      if (abort) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:    if (start && eff_ok) next_state = LOAD;
            LOAD:    next_state = INIT;
            INIT:    if (init_cnt == C_INIT_LAST) next_state = RUN;
            RUN:     if (line_done && line_cnt == v_m_nbr - C_M_WIDTH'(1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   // Outputs are decoded from the upcoming state and registered above.
   always_comb begin
      nxt_busy      = (next_state != IDLE);
      nxt_sc_resetn = (next_state == RUN);
      nxt_sc_enable = (next_state == RUN) && !pause;
      nxt_done      = (next_state == DONE);
      nxt_start_ovr = start && (state != IDLE);
      nxt_cfg_err   = cfg_err;
      if (next_state == LOAD)
         nxt_cfg_err = 1'b0;
      else if (state == IDLE && start && !abort && !eff_ok)
         nxt_cfg_err = 1'b1;
   end

endmodule

// File: tb/tb_scaler_frame_ctl.sv
// Directed self-checking bench for scaler_frame_ctl with hand-computed expectations.
module tb_scaler_frame_ctl;

   logic        clk = 1'b0;
   logic        resetn;
   logic [11:0] cfg_src_w, cfg_src_h, cfg_dst_w, cfg_dst_h;
   logic        cfg_update, start, abort, pause, line_done;
   logic [11:0] h_s_nbr, h_m_nbr, v_s_nbr, v_m_nbr, line_cnt;
   logic        sc_resetn, sc_enable, busy, done, cfg_err, start_ovr;

   int n_compared   = 0;
   int n_mismatched = 0;

   scaler_frame_ctl #(.C_S_WIDTH(12), .C_M_WIDTH(12), .C_INIT_CYC(2)) dut (
      .clk(clk), .resetn(resetn),
      .cfg_src_w(cfg_src_w), .cfg_src_h(cfg_src_h),
      .cfg_dst_w(cfg_dst_w), .cfg_dst_h(cfg_dst_h),
      .cfg_update(cfg_update), .start(start), .abort(abort), .pause(pause),
      .line_done(line_done),
      .h_s_nbr(h_s_nbr), .h_m_nbr(h_m_nbr), .v_s_nbr(v_s_nbr), .v_m_nbr(v_m_nbr),
      .sc_resetn(sc_resetn), .sc_enable(sc_enable), .busy(busy), .done(done),
      .cfg_err(cfg_err), .start_ovr(start_ovr), .line_cnt(line_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One clock with the given single-cycle pulses, then pulses return low.
   task automatic apply_stimulus(input bit upd, input bit st, input bit ld);
      cfg_update = upd;
      start      = st;
      line_done  = ld;
      step();
      cfg_update = 1'b0;
      start      = 1'b0;
      line_done  = 1'b0;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      n_compared++;
      assert (observed === expected) else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   initial begin
      resetn = 1'b0;
      cfg_src_w = '0; cfg_src_h = '0; cfg_dst_w = '0; cfg_dst_h = '0;
      cfg_update = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0; line_done = 1'b0;
      step();
      step();
      check_output("rst_busy", busy, 0);
      check_output("rst_sc_resetn", sc_resetn, 0);
      check_output("rst_sc_enable", sc_enable, 0);
      check_output("rst_done", done, 0);
      check_output("rst_cfg_err", cfg_err, 0);
      check_output("rst_start_ovr", start_ovr, 0);
      check_output("rst_line_cnt", line_cnt, 0);
      check_output("rst_h_s_nbr", h_s_nbr, 0);
      resetn = 1'b1;

      $display("[TB] basic frame 1920x1080 -> 1280x720");
      cfg_src_w = 12'd1920; cfg_src_h = 12'd1080; cfg_dst_w = 12'd1280; cfg_dst_h = 12'd720;
      apply_stimulus(1, 0, 0);
      check_output("upd_busy", busy, 0);
      check_output("upd_active_untouched", h_s_nbr, 0);
      apply_stimulus(0, 1, 0);
      check_output("load_busy", busy, 1);
      check_output("load_sc_resetn", sc_resetn, 0);
      check_output("load_nbr_not_yet", h_m_nbr, 0);
      step();
      check_output("init1_h_s_nbr", h_s_nbr, 1920);
      check_output("init1_h_m_nbr", h_m_nbr, 1280);
      check_output("init1_v_s_nbr", v_s_nbr, 1080);
      check_output("init1_v_m_nbr", v_m_nbr, 720);
      check_output("init1_sc_resetn", sc_resetn, 0);
      step();
      check_output("init2_sc_resetn", sc_resetn, 0);
      step();
      check_output("run_sc_resetn", sc_resetn, 1);
      check_output("run_sc_enable", sc_enable, 1);
      for (int i = 0; i < 10; i++) apply_stimulus(0, 0, 1);
      check_output("run_line_cnt10", line_cnt, 10);

      $display("[TB] overrun start during RUN");
      apply_stimulus(0, 1, 0);
      check_output("ovr_pulse", start_ovr, 1);
      check_output("ovr_busy", busy, 1);
      step();
      check_output("ovr_pulse_end", start_ovr, 0);
      check_output("ovr_line_cnt", line_cnt, 10);

      $display("[TB] frame-boundary update and pause");
      cfg_dst_w = 12'd640;
      apply_stimulus(1, 0, 0);
      check_output("midframe_h_m_nbr", h_m_nbr, 1280);
      pause = 1'b1;
      step();
      check_output("pause_sc_enable", sc_enable, 0);
      step();
      step();
      check_output("pause_line_cnt", line_cnt, 10);
      pause = 1'b0;
      step();
      check_output("unpause_sc_enable", sc_enable, 1);
      for (int i = 0; i < 709; i++) apply_stimulus(0, 0, 1);
      check_output("pre_done_line_cnt", line_cnt, 719);
      check_output("pre_done_done", done, 0);
      apply_stimulus(0, 0, 1);
      check_output("done_pulse", done, 1);
      check_output("done_line_cnt", line_cnt, 720);
      check_output("done_sc_enable", sc_enable, 0);
      check_output("done_sc_resetn", sc_resetn, 0);
      check_output("done_busy", busy, 1);
      check_output("done_h_m_nbr", h_m_nbr, 1280);
      step();
      check_output("idle_done_low", done, 0);
      check_output("idle_busy", busy, 0);
      check_output("idle_line_cnt", line_cnt, 720);

      $display("[TB] second frame with new dst_w, then abort");
      apply_stimulus(0, 1, 0);
      step();
      check_output("f2_h_m_nbr", h_m_nbr, 640);
      check_output("f2_v_m_nbr", v_m_nbr, 720);
      step();
      step();
      for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 1);
      check_output("f2_line_cnt", line_cnt, 3);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check_output("abort_busy", busy, 0);
      check_output("abort_done", done, 0);
      check_output("abort_sc_resetn", sc_resetn, 0);
      check_output("abort_sc_enable", sc_enable, 0);
      check_output("abort_line_cnt_held", line_cnt, 3);
      check_output("abort_cfg_kept", h_m_nbr, 640);
      step();
      check_output("abort_no_late_done", done, 0);

      $display("[TB] invalid config, then same-cycle update+start with dst_h=2");
      cfg_dst_h = 12'd0;
      apply_stimulus(1, 0, 0);
      apply_stimulus(0, 1, 0);
      check_output("inv_cfg_err", cfg_err, 1);
      check_output("inv_busy", busy, 0);
      step();
      check_output("inv_stays_idle", busy, 0);
      cfg_dst_h = 12'd2;
      apply_stimulus(1, 1, 0);
      check_output("same_busy", busy, 1);
      check_output("same_cfg_err_clr", cfg_err, 0);
      step();
      check_output("same_v_m_nbr", v_m_nbr, 2);
      step();
      step();
      apply_stimulus(0, 0, 1);
      check_output("same_line1_done", done, 0);
      apply_stimulus(0, 0, 1);
      check_output("same_done", done, 1);
      check_output("same_line_cnt", line_cnt, 2);
      apply_stimulus(0, 1, 0);
      check_output("done_start_ovr", start_ovr, 1);
      check_output("done_start_busy", busy, 0);
      step();
      check_output("no_chain_busy", busy, 0);
      check_output("no_chain_ovr_end", start_ovr, 0);

      $display("[TB] reset mid-RUN at line 100");
      cfg_dst_h = 12'd720;
      apply_stimulus(1, 0, 0);
      apply_stimulus(0, 1, 0);
      step();
      step();
      step();
      for (int i = 0; i < 100; i++) apply_stimulus(0, 0, 1);
      check_output("mid_line_cnt", line_cnt, 100);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      check_output("mrst_busy", busy, 0);
      check_output("mrst_line_cnt", line_cnt, 0);
      check_output("mrst_h_s_nbr", h_s_nbr, 0);
      check_output("mrst_v_m_nbr", v_m_nbr, 0);
      check_output("mrst_sc_resetn", sc_resetn, 0);
      check_output("mrst_sc_enable", sc_enable, 0);
      check_output("mrst_done", done, 0);
      apply_stimulus(0, 1, 0);
      check_output("mrst_start_cfg_err", cfg_err, 1);
      check_output("mrst_start_busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
